b_line_tx: RTL

Serial symbol transmitter driving the single-bit `B` line consumed by the team's 3-stage `d_ff` detector chain. It takes a parallel word with a start/ready handshake and emits a framed bit sequence in which every symbol holds the line at a constant level for `HOLD` consecutive clocks. With the default `HOLD=3`, each '1' symbol is long enough for the three-flop AND detector to assert. It sits on the stimulus/driver side of the button/line path, feeding the detector directly or through a pin.

---
 rtl/b_line_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/b_line_tx.sv
// b_line_tx: framed serial symbol transmitter for the B detector line.
// Optional even-parity symbol: define B_LINE_TX_PARITY_EN.
module b_line_tx #(
    parameter int DATA_W = 8,
    parameter int HOLD   = 3,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              B
);

    localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int BW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
`ifdef B_LINE_TX_PARITY_EN
        PAR,
`endif
        GAP_ST
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     hold_q, hold_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              b_q, b_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic              sym_end;
    logic              gap_end;
`ifdef B_LINE_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign sym_end = (hold_q == CW'(HOLD - 1));
    assign gap_end = (hold_q == CW'(GAP - 1));

    // Next-state, counters and registered-output precompute
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        b_d     = 1'b0;
`ifdef B_LINE_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRE;
                    hold_d  = '0;
                    bit_d   = BW'(DATA_W - 1);
                    sh_d    = data;
`ifdef B_LINE_TX_PARITY_EN
                    par_d   = ^data;
`endif
                end
            end
            PRE: begin
                if (sym_end) begin
                    state_d = DATA;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            DATA: begin
                if (sym_end) begin
                    hold_d = '0;
                    if (bit_q == '0) begin
`ifdef B_LINE_TX_PARITY_EN
                        state_d = PAR;
`else
                        state_d = GAP_ST;
`endif
                    end else begin
                        bit_d = bit_q - BW'(1);
                        sh_d  = sh_q << 1;
                    end
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
`ifdef B_LINE_TX_PARITY_EN
            PAR: begin
                if (sym_end) begin
                    state_d = GAP_ST;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
`endif
            GAP_ST: begin
                if (gap_end) begin
                    state_d = IDLE;
                    hold_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    hold_d = hold_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase

        unique case (state_d)
            PRE:     b_d = 1'b1;
            DATA:    b_d = sh_d[DATA_W-1];
`ifdef B_LINE_TX_PARITY_EN
            PAR:     b_d = par_d;
`endif
            default: b_d = 1'b0;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State, counters, shift register and output flops
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            hold_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            b_q     <= b_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

`ifdef B_LINE_TX_PARITY_EN
    // Parity of the captured word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign B     = b_q;
    assign done  = done_q;
    assign ready = ready_q;
    assign busy  = ~ready_q;

endmodule
